// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller interface: pipeline status in, enables/flushes out.
// slave = controller side, master = pipeline/driver side.
interface pipeline_hazard_controller_if #(
   parameter int REG_BITS = 3
);
   logic                memRead_EX;
   logic [REG_BITS-1:0] rd_EX;
   logic [REG_BITS-1:0] rs_ID;
   logic [REG_BITS-1:0] rt_ID;
   logic                usesRs_ID;
   logic                usesRt_ID;
   logic                halt_ID;
   logic                branchTaken_EX;
   logic                memBusy;
   logic                resume;
   logic                pcWrite;
   logic                ifidWrite;
   logic                IFFlush;
   logic                IDFlush;
   logic                changeEnable;
   logic                halted;
   logic [15:0]         stallCycles;
   logic [15:0]         flushCount;

   modport master (
      output memRead_EX, rd_EX, rs_ID, rt_ID,
      output usesRs_ID, usesRt_ID, halt_ID,
      output branchTaken_EX, memBusy, resume,
      input  pcWrite, ifidWrite, IFFlush,
      input  IDFlush, changeEnable, halted,
      input  stallCycles, flushCount
   );

   modport slave (
      input  memRead_EX, rd_EX, rs_ID, rt_ID,
      input  usesRs_ID, usesRt_ID, halt_ID,
      input  branchTaken_EX, memBusy, resume,
      output pcWrite, ifidWrite, IFFlush,
      output IDFlush, changeEnable, halted,
      output stallCycles, flushCount
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, HLT drain/halt.
// Ports: clock, reset (sync, active-high), hif (slave modport).
module pipeline_hazard_controller #(
   parameter int REG_BITS     = 3,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic clock,
   input  logic reset,
   pipeline_hazard_controller_if.slave hif
);
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [1:0] DRAIN_INIT =
      2'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  drain_q, drain_d;
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   logic [REG_BITS-1:0] rd_w, rs_w, rt_w;
   logic load_use;
   logic stall_inc, flush_inc;
   logic pc_w, ifid_w, ce_w;
   logic if_fl_w, id_fl_w, halted_w;

   assign rd_w = hif.rd_EX;
   assign rs_w = hif.rs_ID;
   assign rt_w = hif.rt_ID;

   assign load_use = hif.memRead_EX &&
      ((hif.usesRs_ID && rs_w == rd_w) ||
       (hif.usesRt_ID && rt_w == rd_w));

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      pc_w      = 1'b1;
      ifid_w    = 1'b1;
      ce_w      = 1'b1;
      if_fl_w   = 1'b0;
      id_fl_w   = 1'b0;
      halted_w  = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (reset) begin
         pc_w    = 1'b0;
         ifid_w  = 1'b0;
         if_fl_w = 1'b1;
         id_fl_w = 1'b1;
         state_d = RUN;
         drain_d = 2'd0;
      end else begin
         case (state_q)
            RUN, DRAIN: begin
               if (hif.memBusy) begin
                  // Full freeze: state and drain count hold.
                  pc_w      = 1'b0;
                  ifid_w    = 1'b0;
                  ce_w      = 1'b0;
                  stall_inc = 1'b1;
               end else if (hif.branchTaken_EX) begin
                  // A pending HLT was on the wrong path.
                  if_fl_w   = 1'b1;
                  id_fl_w   = 1'b1;
                  flush_inc = 1'b1;
                  state_d   = RUN;
                  drain_d   = 2'd0;
               end else if (state_q == DRAIN) begin
                  pc_w      = 1'b0;
                  ifid_w    = 1'b0;
                  id_fl_w   = 1'b1;
                  stall_inc = 1'b1;
                  if (drain_q == 2'd0) begin
                     state_d = HALT;
                  end else begin
                     drain_d = drain_q - 2'd1;
                  end
               end else if (load_use) begin
                  pc_w      = 1'b0;
                  ifid_w    = 1'b0;
                  id_fl_w   = 1'b1;
                  stall_inc = 1'b1;
               end else if (hif.halt_ID) begin
                  pc_w      = 1'b0;
                  ifid_w    = 1'b0;
                  id_fl_w   = 1'b1;
                  stall_inc = 1'b1;
                  state_d   = DRAIN;
                  drain_d   = DRAIN_INIT;
               end
            end
            HALT: begin
               pc_w     = 1'b0;
               ifid_w   = 1'b0;
               ce_w     = 1'b0;
               halted_w = 1'b1;
               if (hif.resume) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               drain_d = 2'd0;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_inc && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
      if (flush_inc && flush_q != 16'hFFFF) begin
         flush_d = flush_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RUN;
         drain_q <= 2'd0;
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign hif.pcWrite      = pc_w;
   assign hif.ifidWrite    = ifid_w;
   assign hif.changeEnable = ce_w;
   assign hif.IFFlush      = if_fl_w;
   assign hif.IDFlush      = id_fl_w;
   assign hif.halted       = halted_w;
   assign hif.stallCycles  = stall_q;
   assign hif.flushCount   = flush_q;
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter REG_BITS, default 3, register-address width (8-entry register file).
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, number of cycles allowed for older instructions to retire before halting (range 1..3).
REQ-003 clock  input  1  Single clock; all state updates on posedge clock.
REQ-004 reset  input  1  Reset; synchronous and active-high.
REQ-005 memRead_EX  input  1  Instruction in EX is a load.
REQ-006 rd_EX  input  REG_BITS  Destination register of the instruction in EX.
REQ-007 rs_ID, rt_ID  input  REG_BITS each  Source registers of the instruction in ID.
REQ-008 usesRs_ID, usesRt_ID  input  1 each  The ID instruction actually reads rs / rt.
REQ-009 halt_ID  input  1  Instruction in ID is HLT.
REQ-010 branchTaken_EX  input  1  Branch in EX resolved taken this cycle.
REQ-011 memBusy  input  1  Data memory not ready; whole pipeline must freeze.
REQ-012 resume  input  1  External restart request, sampled only in HALT.
REQ-013 pcWrite, ifidWrite  output  1 each  PC / IF-ID register load enables.
REQ-014 IFFlush  output  1  Clear IF/ID register.
REQ-015 IDFlush, changeEnable  output  1 each  Flush and load enable driving the ID/EX register.
REQ-016 halted  output  1  Processor stopped.
REQ-017 stallCycles, flushCount  output  16 each  Saturating performance counters.

Function
REQ-018 SHALL implement FSM states RUN, DRAIN, HALT; all control outputs SHALL be combinational from state and current inputs (same-cycle effect).
REQ-019 loadUse SHALL be memRead_EX AND ((usesRs_ID AND rs_ID==rd_EX) OR (usesRt_ID AND rt_ID==rd_EX)).
REQ-020 Priority in RUN and DRAIN: memBusy > branchTaken_EX > loadUse > halt_ID.
REQ-021 memBusy (RUN/DRAIN): pcWrite=ifidWrite=changeEnable=0, IFFlush=IDFlush=0; state and drain counter SHALL hold; other inputs ignored.
REQ-022 branchTaken_EX (RUN/DRAIN): pcWrite=ifidWrite=changeEnable=1, IFFlush=IDFlush=1; next state RUN; flushCount increments.
REQ-023 loadUse in RUN: pcWrite=ifidWrite=0, changeEnable=1, IDFlush=1, IFFlush=0 (one bubble); state stays RUN.
REQ-024 halt_ID in RUN (no higher event): pcWrite=ifidWrite=0, changeEnable=1, IDFlush=1; next state DRAIN, drain counter loaded with DRAIN_CYCLES-1.
REQ-025 RUN with no event: pcWrite=ifidWrite=changeEnable=1, flushes 0.
REQ-026 DRAIN (no memBusy/branch): pcWrite=ifidWrite=0, changeEnable=1, IDFlush=1; counter decrements each cycle; at counter 0 next state HALT; loadUse and halt_ID ignored.
REQ-027 branchTaken_EX in DRAIN SHALL cancel the halt (HLT was younger, wrong-path) and return to RUN.
REQ-028 HALT: pcWrite=ifidWrite=0, changeEnable=0, flushes 0, halted=1; memBusy, branch, loadUse ignored.
REQ-029 resume in HALT: next state RUN; halted still 1 in that cycle, 0 from the next; resume outside HALT ignored.
REQ-030 stallCycles SHALL increment on every cycle with pcWrite=0 in RUN or DRAIN (includes memBusy, loadUse, drain); not in HALT or reset.
REQ-031 Both counters SHALL saturate at 0xFFFF (no wrap).

Reset
REQ-032 While reset=1: pcWrite=ifidWrite=0, changeEnable=1, IDFlush=IFFlush=1, halted=0; counters take no increments.
REQ-033 On the clock edge with reset=1: state=RUN, drain counter=0, stallCycles=flushCount=0, regardless of current state (including DRAIN, HALT, mid-memBusy).

Verification
REQ-034 memRead_EX=1, rd_EX=3, rs_ID=3, usesRs_ID=1 for one cycle -> pcWrite=0, IDFlush=1 that cycle; next cycle all enables 1; stallCycles=1.
REQ-035 Same as REQ-034 but usesRs_ID=0, rt_ID=3, usesRt_ID=0 -> no stall, stallCycles=0.
REQ-036 branchTaken_EX=1 and loadUse=1 same cycle -> IFFlush=IDFlush=1, pcWrite=1; flushCount=1, stallCycles=0.
REQ-037 halt_ID=1 in RUN, DRAIN_CYCLES=3 -> 1 RUN cycle + 3 DRAIN cycles with IDFlush=1, then halted=1; resume pulse -> halted=0 one cycle later, pcWrite=1.
REQ-038 halt_ID then branchTaken_EX on 2nd DRAIN cycle -> flush, back to RUN, halted never 1.
REQ-039 memBusy=1 for 4 cycles during DRAIN -> outputs frozen, drain counter held, HALT reached 4 cycles later; stallCycles counts the frozen cycles; counter preset 0xFFFE then 3 stalls -> 0xFFFF.
